// File: rtl/stoch_job_sequencer_if.sv
// Bundle of request, engine and result signals between requesters/consumer and the sequencer.
// Result handshake: a transfer happens on a rising edge where res_valid and res_ready are both high;
// res_valid, res_data and res_id stay stable from the rise of res_valid until that edge.
interface stoch_job_sequencer_if;
    logic [1:0] req;
    logic [8:0] op_a0;
    logic [8:0] op_b0;
    logic [8:0] op_a1;
    logic [8:0] op_b1;
    logic [1:0] mode;
    logic [1:0] grant;
    logic       busy;
    logic       abort;
    logic       eng_load;
    logic [8:0] eng_a;
    logic [8:0] eng_b;
    logic       eng_mode;
    logic       eng_bit;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_data;
    logic       res_id;

    modport master (
        output req, op_a0, op_b0, op_a1, op_b1, mode, abort, eng_bit, res_ready,
        input  grant, busy, eng_load, eng_a, eng_b, eng_mode, res_valid, res_data, res_id
    );

    modport slave (
        input  req, op_a0, op_b0, op_a1, op_b1, mode, abort, eng_bit, res_ready,
        output grant, busy, eng_load, eng_a, eng_b, eng_mode, res_valid, res_data, res_id
    );
endinterface

// File: rtl/stoch_job_sequencer.sv
// Round-robin sharing of one stochastic add/multiply engine between two requesters:
// load operands, wait for the engine pipeline to settle, count ones over a 2^WIN_LOG2 window.
module stoch_job_sequencer #(
    parameter int WIN_LOG2 = 17,
    parameter int SETTLE   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stoch_job_sequencer_if.slave  bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int CW = WIN_LOG2;
    localparam int OW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] RUN_LAST    = {CW{1'b1}};
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [1:0]    grant_q, grant_d;
    logic          eng_load_q, eng_load_d;
    logic [8:0]    eng_a_q, eng_a_d;
    logic [8:0]    eng_b_q, eng_b_d;
    logic          eng_mode_q, eng_mode_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [OW-1:0] ones_q, ones_d;
    logic          res_valid_q, res_valid_d;
    logic [9:0]    res_data_q, res_data_d;
    logic          res_id_q, res_id_d;

    logic          win;
    logic [OW-1:0] ones_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            grant_q     <= 2'b00;
            eng_load_q  <= 1'b0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            eng_mode_q  <= 1'b0;
            cyc_q       <= '0;
            ones_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            eng_load_q  <= eng_load_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            eng_mode_q  <= eng_mode_d;
            cyc_q       <= cyc_d;
            ones_q      <= ones_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = 2'b00;
        eng_load_d  = 1'b0;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        eng_mode_d  = eng_mode_q;
        cyc_d       = cyc_q;
        ones_d      = ones_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        // On a tie the requester that did not win last time goes next.
        win      = (bus.req == 2'b10) || ((bus.req == 2'b11) && !last_q);
        ones_inc = ones_q + OW'(bus.eng_bit);

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    eng_a_d    = win ? bus.op_a1 : bus.op_a0;
                    eng_b_d    = win ? bus.op_b1 : bus.op_b0;
                    eng_mode_d = bus.mode[win];
                    last_d     = win;
                    grant_d    = win ? 2'b10 : 2'b01;
                    eng_load_d = 1'b1;
                    cyc_d      = '0;
                    ones_d     = '0;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    cyc_d   = '0;
                    ones_d  = '0;
                    state_d = S_IDLE;
                end else if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    cyc_d   = '0;
                    ones_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    ones_d = ones_inc;
                    if (cyc_q == RUN_LAST) begin
                        cyc_d       = '0;
                        res_valid_d = 1'b1;
                        res_data_d  = ones_inc[CW -: 10];
                        res_id_d    = last_q;
                        state_d     = S_DONE;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    ones_d      = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.eng_load  = eng_load_q;
    assign bus.eng_a     = eng_a_q;
    assign bus.eng_b     = eng_b_q;
    assign bus.eng_mode  = eng_mode_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/stoch_job_sequencer.md
Name: stoch_job_sequencer

Overview:
- Controller that shares one stochastic add/multiply engine between two requesters.
- Round-robin arbitration between requesters. Loads the winner's 9-bit operands and mode into the engine, waits a settle period, then counts engine output ones over a 2^WIN_LOG2-cycle window.
- Returns a 10-bit probability result with a valid/ready handshake, tagged with the requester ID.

Parameters:
- WIN_LOG2, 17, log2 of evaluation window length in cycles; legal range 9..20.
- SETTLE, 2, cycles between engine load and first counted bit (LFSR/comparator pipeline); legal range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req  input  2  request per requester; held high until granted
- op_a0 / op_b0  input  9 each  requester 0 operands
- op_a1 / op_b1  input  9 each  requester 1 operands
- mode  input  2  per-requester op select: 0 = multiply (XNOR), 1 = scaled add (mux)
- grant  output  2  one-hot, one-cycle pulse when a request is accepted
- busy  output  1  high whenever state is not IDLE
- abort  input  1  synchronous cancel of the current job
- eng_load  output  1  one-cycle pulse; engine latches eng_a/eng_b/eng_mode
- eng_a / eng_b  output  9 each  operands to engine, stable from load until next load
- eng_mode  output  1  mode to engine
- eng_bit  input  1  engine stochastic output bit, one per cycle
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  10  count[WIN_LOG2:WIN_LOG2-9]
- res_id  output  1  requester that owns res_data

Behaviour:
- Reset (rst_n low at a clock edge) applies regardless of any other input:
  - State goes to IDLE; grant, eng_load, res_valid, busy = 0.
  - eng_a, eng_b, eng_mode, res_data, res_id = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - The bit counter and the cycle counter clear.
- States are IDLE, SETTLE, RUN and DONE.
- IDLE, on an edge with any req bit high:
  - Select the winner: the only requester if one; otherwise the one not equal to last.
  - Capture its operands and mode into eng_a/eng_b/eng_mode and set last to the winner.
  - Next cycle grant[winner] = 1 and eng_load = 1, both for exactly one cycle; state goes to SETTLE.
  - req low at the sampling edge is not serviced; no grant is issued.
- SETTLE lasts exactly SETTLE cycles, with eng_bit ignored. The first SETTLE cycle is the eng_load cycle.
- RUN lasts exactly 2^WIN_LOG2 cycles:
  - eng_bit is sampled every cycle into a WIN_LOG2+1-bit ones counter.
  - No wrap is possible: the maximum count 2^WIN_LOG2 fits.
  - After the last counted cycle, go to DONE.
  - res_valid rises on the first DONE cycle, with res_data = count[WIN_LOG2:WIN_LOG2-9] and res_id = winner.
  - Example values: all ones gives 512; all zeros gives 0.
- DONE:
  - res_valid, res_data and res_id are held stable until an edge with res_ready high.
  - On that edge, res_valid falls and the state goes to IDLE.
  - res_ready already high on the first DONE cycle completes the transfer in that single cycle.
  - Arbitration for the next job starts in IDLE on the following edge, giving a minimum of one idle cycle between jobs.
- Requests arriving while busy stay pending; they are arbitrated in IDLE by the same round-robin rule.
- abort high at an edge in SETTLE or RUN:
  - State goes to IDLE and the counter clears; no res_valid is produced.
  - last keeps the aborted winner.
- abort in IDLE or DONE has no effect; a DONE result is never dropped.
- abort and rst_n low on the same edge: reset wins.
- Total latency from grant to res_valid is SETTLE + 2^WIN_LOG2 cycles.
- busy is high from the grant cycle through the last DONE cycle.

Test Plan:
- WIN_LOG2=9, SETTLE=2, req=01, op_a0=0x100, mode=0, eng_bit held 1:
  - Required response: grant=01 pulse with eng_load the same cycle and eng_a=0x100.
  - res_valid exactly 514 cycles after grant, res_data=512, res_id=0.
- Same setup with eng_bit alternating 1/0 starting in the first RUN cycle, then repeated with eng_bit held 0:
  - Alternating eng_bit gives res_data=256.
  - eng_bit held 0 gives res_data=0.
- req=11 held continuously with res_ready=1:
  - Grant order is 01, 10, 01.
  - res_id sequence is 0, 1, 0.
  - Exactly one idle cycle between each DONE and the next grant.
- Abort 100 cycles into RUN:
  - busy falls the next cycle and no res_valid appears.
  - A pending req=10 is then granted with a fresh count: eng_bit=1 gives 512.
- Backpressure: res_ready low for 5 DONE cycles, then high:
  - res_valid, res_data and res_id remain stable throughout.
  - Exactly one transfer occurs.
- rst_n low mid-RUN and mid-DONE:
  - All outputs are 0 the next cycle.
  - The next req=11 is granted to requester 0.
